// File: rtl/abc_mac_sched_pkg.sv
// abc_mac_sched_pkg: shared types and helpers for the (A+B)*C scheduler.
//   - state_t: scheduler FSM states
//   - DEF_N_CH / DEF_W: default channel count and operand width
//   - res_width(): result width 2W+1
//   - rr_grant() / prio_grant(): arbitration over an up-to-8-bit valid vector
package abc_mac_sched_pkg;

  localparam int unsigned DEF_N_CH = 3;
  localparam int unsigned DEF_W    = 8;
  localparam int unsigned MAX_CH   = 8;
  localparam int unsigned MAX_CH_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int unsigned res_width(input int unsigned w);
    return 2 * w + 1;
  endfunction

  // First valid channel after 'last', wrapping modulo n_ch. Walking the search
  // order backwards lets the nearest hit overwrite the farther ones.
  function automatic logic [MAX_CH_W-1:0] rr_grant(input logic [MAX_CH-1:0]   valid,
                                                   input logic [MAX_CH_W-1:0] last,
                                                   input int unsigned         n_ch);
    logic [MAX_CH_W-1:0] g;
    int unsigned         idx;
    g = '0;
    for (int unsigned i = MAX_CH; i > 0; i--) begin
      idx = (32'(last) + i) % n_ch;
      if (i <= n_ch && valid[MAX_CH_W'(idx)]) g = MAX_CH_W'(idx);
    end
    return g;
  endfunction

  // Lowest valid index wins.
  function automatic logic [MAX_CH_W-1:0] prio_grant(input logic [MAX_CH-1:0] valid);
    logic [MAX_CH_W-1:0] g;
    g = '0;
    for (int i = int'(MAX_CH) - 1; i >= 0; i--) begin
      if (valid[i]) g = MAX_CH_W'(i);
    end
    return g;
  endfunction

endpackage

// File: rtl/abc_mac_sched_if.sv
// abc_mac_sched_if: Avalon-ST requester sink and result source bundle.
//   asi_in_data/asi_in_valid/asi_in_ready : N_CH operand sinks, slice i = {C,B,A}
//   aso_out_data/channel/valid/ready      : tagged (A+B)*C result source
//   modport slave  : scheduler side
//   modport master : producer/consumer side
interface abc_mac_sched_if #(
  parameter int unsigned N_CH = 3,
  parameter int unsigned W    = 8
);
  localparam int unsigned CH_W = $clog2(N_CH);

  logic [N_CH*3*W-1:0] asi_in_data;
  logic [N_CH-1:0]     asi_in_valid;
  logic [N_CH-1:0]     asi_in_ready;
  logic [2*W:0]        aso_out_data;
  logic [CH_W-1:0]     aso_out_channel;
  logic                aso_out_valid;
  logic                aso_out_ready;

  modport slave (
    input  asi_in_data, asi_in_valid, aso_out_ready,
    output asi_in_ready, aso_out_data, aso_out_channel, aso_out_valid
  );

  modport master (
    output asi_in_data, asi_in_valid, aso_out_ready,
    input  asi_in_ready, aso_out_data, aso_out_channel, aso_out_valid
  );
endinterface

// File: rtl/abc_shift_mul.sv
// abc_shift_mul: sequential shift-add multiplier, one multiplier bit per cycle.
//   csi_clk, rsi_reset : clock, async active-high reset
//   i_start            : load i_sum / i_c and clear the accumulator
//   i_sum  [W:0]       : multiplicand (A+B)
//   i_c    [W-1:0]     : multiplier C, consumed LSB first
//   o_done             : one-cycle pulse, W cycles after i_start
//   o_prod [2W:0]      : product, valid from o_done onward
module abc_shift_mul
  import abc_mac_sched_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  input  logic              i_start,
  input  logic [W:0]        i_sum,
  input  logic [W-1:0]      i_c,
  output logic              o_done,
  output logic [2*W:0]      o_prod
);
  localparam int unsigned PW    = res_width(W);
  localparam int unsigned CNT_W = $clog2(W);

  logic [PW-1:0]    r_addend;
  logic [PW-1:0]    r_acc;
  logic [W-1:0]     r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_done;

  // Addend shifts left while C shifts right, so bit k adds sum << k.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      r_addend <= '0;
      r_acc    <= '0;
      r_c      <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_addend <= PW'(i_sum);
        r_c      <= i_c;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_run    <= 1'b1;
      end else if (r_run) begin
        if (r_c[0]) r_acc <= r_acc + r_addend;
        r_addend <= r_addend << 1;
        r_c      <= r_c >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(W - 1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/abc_mac_sched.sv
// abc_mac_sched: shares one shift-add (A+B)*C unit among N_CH Avalon-ST requesters.
//   csi_clk, rsi_reset : clock, async active-high reset
//   bus (slave)        : per-channel operand sinks and tagged result source
//   coe_busy           : high whenever the FSM is not in IDLE
// Arbitration is round-robin; defining ABC_MAC_SCHED_STRICT_PRIO_EN switches
// to fixed priority (lowest index wins).
module abc_mac_sched
  import abc_mac_sched_pkg::*;
#(
  parameter int unsigned N_CH = DEF_N_CH,
  parameter int unsigned W    = DEF_W
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  abc_mac_sched_if.slave    bus,
  output logic              coe_busy
);
  localparam int unsigned RW   = res_width(W);
  localparam int unsigned CH_W = $clog2(N_CH);
  localparam int unsigned DW   = 3 * W;
  localparam int unsigned SW   = W + 1;

  state_t          r_state;
  state_t          w_next;
  logic [CH_W-1:0] r_last_grant;
  logic [CH_W-1:0] r_out_channel;
  logic [CH_W-1:0] w_grant;
  logic [N_CH-1:0] w_ready;
  logic [MAX_CH-1:0] w_valid8;
  logic            w_any_valid;
  logic            w_xfer;
  logic            w_mul_done;
  logic [DW-1:0]   w_op;
  logic [SW-1:0]   w_sum;
  logic [RW-1:0]   w_prod;
  logic [RW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_busy;

  assign w_valid8    = MAX_CH'(bus.asi_in_valid);
  assign w_any_valid = |bus.asi_in_valid;

`ifdef ABC_MAC_SCHED_STRICT_PRIO_EN
  assign w_grant = CH_W'(prio_grant(w_valid8));
`else
  assign w_grant = CH_W'(rr_grant(w_valid8, MAX_CH_W'(r_last_grant), N_CH));
`endif

  // Operands of the granted channel.
  assign w_op  = bus.asi_in_data[32'(w_grant)*DW +: DW];
  assign w_sum = SW'(w_op[W-1:0]) + SW'(w_op[2*W-1:W]);

  abc_shift_mul #(.W(W)) u_mul (
    .csi_clk   (csi_clk),
    .rsi_reset (rsi_reset),
    .i_start   (w_xfer),
    .i_sum     (w_sum),
    .i_c       (w_op[DW-1:2*W]),
    .o_done    (w_mul_done),
    .o_prod    (w_prod)
  );

  // State register.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer)            w_next = MUL;
      MUL:     if (w_mul_done)        w_next = OUT;
      OUT:     if (bus.aso_out_ready) w_next = IDLE;
      default:                        w_next = IDLE;
    endcase
  end

  // Combinational accept: the grant's ready bit, only in IDLE with a request.
  always_comb begin
    w_ready = '0;
    w_xfer  = 1'b0;
    if (r_state == IDLE && w_any_valid) begin
      w_ready[w_grant] = 1'b1;
      w_xfer           = 1'b1;
    end
  end

  // Registered outputs and grant history.
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      r_last_grant  <= CH_W'(N_CH - 1);
      r_out_channel <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_last_grant  <= w_grant;
        r_out_channel <= w_grant;
      end
      if (r_state == MUL && w_mul_done) r_out_data <= w_prod;
      r_out_valid <= (w_next == OUT);
      r_busy      <= (w_next != IDLE);
    end
  end

  assign bus.asi_in_ready    = w_ready;
  assign bus.aso_out_data    = r_out_data;
  assign bus.aso_out_channel = r_out_channel;
  assign bus.aso_out_valid   = r_out_valid;
  assign coe_busy            = r_busy;

endmodule

// File: tb/tb_abc_mac_sched.sv
// tb_abc_mac_sched: directed self-checking bench for abc_mac_sched (N_CH=3, W=8).
module tb_abc_mac_sched;
  localparam int unsigned N_CH = 3;
  localparam int unsigned W    = 8;
  localparam int unsigned DW   = 3 * W;

  logic csi_clk   = 1'b0;
  logic rsi_reset = 1'b1;
  logic coe_busy;

  int total = 0;
  int bad   = 0;

  always #5 csi_clk = ~csi_clk;

  abc_mac_sched_if #(.N_CH(N_CH), .W(W)) u_if ();

  abc_mac_sched #(.N_CH(N_CH), .W(W)) u_dut (
    .csi_clk   (csi_clk),
    .rsi_reset (rsi_reset),
    .bus       (u_if),
    .coe_busy  (coe_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    u_if.asi_in_data[ch*DW +: DW] = {c, b, a};
  endtask

  // Request on one channel from IDLE; drop valid right after the transfer edge.
  task automatic issue(input int ch, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    set_ch(ch, a, b, c);
    u_if.asi_in_valid = 3'(1 << ch);
    @(posedge csi_clk);
    @(negedge csi_clk);
    u_if.asi_in_valid = '0;
  endtask

  // Bounded wait for a result, then check it.
  task automatic expect_out(input string tag, input int chan, input int data);
    int cyc;
    cyc = 0;
    while (u_if.aso_out_valid !== 1'b1 && cyc < 50) begin
      @(negedge csi_clk);
      cyc++;
    end
    chk({tag, "_valid"}, 32'(u_if.aso_out_valid), 32'd1);
    chk({tag, "_chan"},  32'(u_if.aso_out_channel), 32'(chan));
    chk({tag, "_data"},  32'(u_if.aso_out_data), 32'(data));
  endtask

  task automatic accept();
    u_if.aso_out_ready = 1'b1;
    @(posedge csi_clk);
    @(negedge csi_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    logic ok;
    int order2 [4];
    int data2  [3];
    int order6 [3];
    logic [7:0] tv [3][3];
    int tv_exp [3];

    order2 = '{0, 1, 2, 0};
    data2  = '{9, 60, 135};
`ifdef ABC_MAC_SCHED_STRICT_PRIO_EN
    order6 = '{0, 0, 0};
`else
    order6 = '{2, 0, 2};
`endif
    tv     = '{'{8'd255, 8'd255, 8'd255}, '{8'd0, 8'd0, 8'd255}, '{8'd255, 8'd255, 8'd1}};
    tv_exp = '{130050, 0, 510};

    u_if.asi_in_data   = '0;
    u_if.asi_in_valid  = '0;
    u_if.aso_out_ready = 1'b0;
    rsi_reset = 1'b1;
    repeat (2) @(negedge csi_clk);
    chk("rst_ready", 32'(u_if.asi_in_ready), 32'd0);
    chk("rst_valid", 32'(u_if.aso_out_valid), 32'd0);
    chk("rst_data",  32'(u_if.aso_out_data), 32'd0);
    chk("rst_chan",  32'(u_if.aso_out_channel), 32'd0);
    chk("rst_busy",  32'(coe_busy), 32'd0);
    rsi_reset = 1'b0;
    @(negedge csi_clk);

    // Basic transaction and latency.
    set_ch(0, 8'd3, 8'd4, 8'd5);
    u_if.asi_in_valid  = 3'b001;
    u_if.aso_out_ready = 1'b1;
    #1;
    chk("t1_ready", 32'(u_if.asi_in_ready), 32'd1);
    @(posedge csi_clk);
    @(negedge csi_clk);
    u_if.asi_in_valid = '0;
    chk("t1_busy0", 32'(coe_busy), 32'd1);
    first = 0;
    ok    = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge csi_clk);
      @(negedge csi_clk);
      if (coe_busy !== 1'b1) ok = 1'b0;
      if (u_if.aso_out_valid === 1'b1) begin
        first = k;
        break;
      end
    end
    chk("t1_latency", 32'(first), 32'(W + 1));
    chk("t1_busy",    32'(ok), 32'd1);
    chk("t1_data",    32'(u_if.aso_out_data), 32'd35);
    chk("t1_chan",    32'(u_if.aso_out_channel), 32'd0);
    accept();
    chk("t1_done_valid", 32'(u_if.aso_out_valid), 32'd0);
    chk("t1_done_busy",  32'(coe_busy), 32'd0);

    // Round-robin with all channels requesting, after a fresh reset.
    rsi_reset = 1'b1;
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    set_ch(0, 8'd1,  8'd2,  8'd3);
    set_ch(1, 8'd10, 8'd20, 8'd2);
    set_ch(2, 8'd7,  8'd8,  8'd9);
    u_if.asi_in_valid = 3'b111;
    #1;
    chk("t2_ready_first", 32'(u_if.asi_in_ready), 32'd1);
    for (int n = 0; n < 4; n++) begin
      expect_out($sformatf("t2_r%0d", n), order2[n], data2[order2[n]]);
      if (n == 3) u_if.asi_in_valid = '0;
      accept();
      if (n < 3) chk($sformatf("t2_ready%0d", n), 32'(u_if.asi_in_ready), 32'(1 << order2[n+1]));
    end

    // Corner operand values.
    for (int t = 0; t < 3; t++) begin
      issue(1, tv[t][0], tv[t][1], tv[t][2]);
      expect_out($sformatf("t3_v%0d", t), 1, tv_exp[t]);
      accept();
    end

    // Back-pressure with a competing request waiting.
    u_if.aso_out_ready = 1'b0;
    issue(2, 8'd2, 8'd3, 8'd4);
    set_ch(0, 8'd5, 8'd6, 8'd7);
    u_if.asi_in_valid = 3'b001;
    #1;
    chk("t4_no_ready_mul", 32'(u_if.asi_in_ready), 32'd0);
    expect_out("t4", 2, 20);
    ok = 1'b1;
    repeat (10) begin
      @(negedge csi_clk);
      if (u_if.aso_out_valid !== 1'b1 || u_if.aso_out_data !== 17'd20 ||
          u_if.aso_out_channel !== 2'd2 || u_if.asi_in_ready !== 3'b000) ok = 1'b0;
    end
    chk("t4_stable", 32'(ok), 32'd1);
    u_if.aso_out_ready = 1'b1;
    @(posedge csi_clk);
    @(negedge csi_clk);
    chk("t4_idle_busy",  32'(coe_busy), 32'd0);
    chk("t4_idle_ready", 32'(u_if.asi_in_ready), 32'd1);
    @(posedge csi_clk);
    @(negedge csi_clk);
    u_if.asi_in_valid = '0;
    expect_out("t4_next", 0, 77);
    accept();

    // Reset during the third MUL cycle.
    issue(1, 8'd9, 8'd9, 8'd9);
    @(posedge csi_clk);
    @(posedge csi_clk);
    @(negedge csi_clk);
    rsi_reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(u_if.aso_out_valid), 32'd0);
    chk("t5_rst_busy",  32'(coe_busy), 32'd0);
    chk("t5_rst_ready", 32'(u_if.asi_in_ready), 32'd0);
    chk("t5_rst_data",  32'(u_if.aso_out_data), 32'd0);
    chk("t5_rst_chan",  32'(u_if.aso_out_channel), 32'd0);
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    ok = 1'b1;
    repeat (15) begin
      @(negedge csi_clk);
      if (u_if.aso_out_valid !== 1'b0) ok = 1'b0;
    end
    chk("t5_discarded", 32'(ok), 32'd1);
    u_if.asi_in_valid = 3'b111;
    #1;
    chk("t5_grant0", 32'(u_if.asi_in_ready), 32'd1);
    @(posedge csi_clk);
    @(negedge csi_clk);
    u_if.asi_in_valid = '0;
    expect_out("t5_next", 0, 77);
    accept();

    // Channels 0 and 2 competing; then channel 0 withdraws.
    set_ch(0, 8'd1, 8'd1, 8'd1);
    set_ch(2, 8'd3, 8'd3, 8'd3);
    u_if.asi_in_valid = 3'b101;
    for (int n = 0; n < 3; n++) begin
      expect_out($sformatf("t6_r%0d", n), order6[n], (order6[n] == 0) ? 2 : 18);
      if (n == 2) u_if.asi_in_valid = 3'b100;
      accept();
    end
    expect_out("t6_last", 2, 18);
    u_if.asi_in_valid = '0;
    accept();
    chk("t6_idle", 32'(coe_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
